backprop_controll_gen: RTL and testbench

//  Upstream sequencer for diff_backprop_reg; it opens each backward pass.
//  On start it computes the per-lane output cost derivative (predict - target, Q8.8).
//  It then walks layers last->first and steps 0..steps_per_layer-1, emitting the

---
 rtl/backprop_controll_gen.sv | 167 ++++++++++++++++
 tb/tb_backprop_controll_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/backprop_controll_gen.sv
// -----------------------------------------------------------------------------
// backprop_controll_gen
//
// Upstream sequencer for diff_backprop_reg. A start request opens a backward
// pass: one cycle computes the per-lane output cost derivative
// (predict - target, signed Q8.8). The pass then walks layers from last to
// first and, within each layer, steps 0..steps_per_layer-1, emitting one
// control word per unstalled cycle.
//
// Ports
//   clk               in   rising-edge clock
//   reset             in   synchronous active-high reset (wins over all inputs)
//   start             in   begin a pass; only honoured in IDLE
//   stall             in   freeze sequencing for this cycle
//   predict_value     in   size lanes of data_size bits, lane0 in the MSBs
//   target            in   size lanes of data_size bits, lane0 in the MSBs
//   diff_cost         out  registered predict - target, held until next pass
//   backprop_controll out  {active, first, layer[31:0], step[31:0]}, registered
//   busy              out  high while in COST or RUN
//   done              out  one-cycle pulse at the end of a pass
//
// Configuration macro
//   BACKPROP_COST_SAT_EN  defined: out-of-range lane differences saturate.
//                         undefined: differences wrap to data_size bits.
// -----------------------------------------------------------------------------
module backprop_controll_gen #(
    parameter int size                   = 3,
    parameter int data_size              = 16,
    parameter int layer_count            = 4,
    parameter int steps_per_layer        = 3,
    parameter int backprop_controll_size = 66
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              stall,
    input  logic [size*data_size-1:0]         predict_value,
    input  logic [size*data_size-1:0]         target,
    output logic [size*data_size-1:0]         diff_cost,
    output logic [backprop_controll_size-1:0] backprop_controll,
    output logic                              busy,
    output logic                              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COST = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [31:0] LAST_LAYER = 32'(layer_count - 1);
    localparam logic [31:0] LAST_STEP  = 32'(steps_per_layer - 1);

    state_t                              state_q, state_d;
    logic [31:0]                         layer_q, layer_d;
    logic [31:0]                         step_q,  step_d;
    logic [backprop_controll_size-1:0]   ctrl_q,  ctrl_d;
    logic [size*data_size-1:0]           diff_q,  diff_d;
    logic                                busy_q,  busy_d;
    logic                                done_q,  done_d;

    logic [size*data_size-1:0]           diff_calc;

    // Reduce a (data_size+1)-bit difference back to data_size bits. Overflow
    // is detected by the top two bits disagreeing.
    function automatic logic [data_size-1:0] reduce_diff(input logic [data_size:0] d);
`ifdef BACKPROP_COST_SAT_EN
        if (d[data_size] != d[data_size-1]) begin
            return d[data_size] ? {1'b1, {(data_size-1){1'b0}}}
                                : {1'b0, {(data_size-1){1'b1}}};
        end
        return d[data_size-1:0];
`else
        return d[data_size-1:0];
`endif
    endfunction

    // Lane g occupies the g-th slice counting down from the MSB end.
    for (genvar g = 0; g < size; g++) begin : g_lane
        localparam int HI = (size - g) * data_size - 1;
        logic signed [data_size:0] lane_sub;

        assign lane_sub = $signed({predict_value[HI], predict_value[HI -: data_size]})
                        - $signed({target[HI], target[HI -: data_size]});
        assign diff_calc[HI -: data_size] = reduce_diff(lane_sub);
    end

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        step_d  = step_q;
        ctrl_d  = '0;
        diff_d  = diff_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The done pulse is visible while already back in IDLE; a
                // start coinciding with it must not open a new pass.
                if (start && !done_q) begin
                    state_d = S_COST;
                end
            end
            S_COST: begin
                diff_d  = diff_calc;
                layer_d = LAST_LAYER;
                step_d  = 32'd0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (stall) begin
                    // Keep the last layer/step visible but drop active/first.
                    ctrl_d = {2'b00, ctrl_q[63:0]};
                end else begin
                    ctrl_d = {1'b1, (step_q == 32'd0), layer_q, step_q};
                    if (step_q == LAST_STEP) begin
                        step_d = 32'd0;
                        if (layer_q == 32'd0) begin
                            state_d = S_DONE;
                        end else begin
                            layer_d = layer_q - 32'd1;
                        end
                    end else begin
                        step_d = step_q + 32'd1;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered from the next state so busy tracks COST/RUN directly.
        busy_d = (state_d == S_COST) || (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            step_q  <= '0;
            ctrl_q  <= '0;
            diff_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            step_q  <= step_d;
            ctrl_q  <= ctrl_d;
            diff_q  <= diff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign diff_cost         = diff_q;
    assign backprop_controll = ctrl_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_backprop_controll_gen.sv
module tb_backprop_controll_gen;

    localparam int SZ  = 3;
    localparam int DW  = 16;
    localparam int LC  = 4;
    localparam int SPL = 3;
    localparam int CW  = 66;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic                 stall;
    logic [SZ*DW-1:0]     predict_value;
    logic [SZ*DW-1:0]     target;
    logic [SZ*DW-1:0]     diff_cost;
    logic [CW-1:0]        backprop_controll;
    logic                 busy;
    logic                 done;

    backprop_controll_gen #(
        .size(SZ), .data_size(DW), .layer_count(LC),
        .steps_per_layer(SPL), .backprop_controll_size(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .predict_value(predict_value), .target(target),
        .diff_cost(diff_cost), .backprop_controll(backprop_controll),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SZ*DW-1:0] p;
        logic [SZ*DW-1:0] t;
        logic [SZ*DW-1:0] d_wrap;
        logic [SZ*DW-1:0] d_sat;
    } vec_t;

    vec_t          vecs[3];
    logic [CW-1:0] sb[$];
    int            n_checks;
    int            n_fail;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [SZ*DW-1:0] exp_diff(input vec_t v);
`ifdef BACKPROP_COST_SAT_EN
        return v.d_sat;
`else
        return v.d_wrap;
`endif
    endfunction

    // One full pass: pushes the expected word stream, optionally stalls before
    // word index stall_k for stall_len cycles, optionally pokes start mid-run
    // and on the done cycle.
    task automatic run_pass(input vec_t v, input int stall_k, input int stall_len, input bit poke);
        int            n;
        bit            seen_done;
        logic [CW-1:0] exp_w;
        logic [CW-1:0] held;
        logic [SZ*DW-1:0] ed;

        ed = exp_diff(v);
        predict_value = v.p;
        target        = v.t;
        sb.delete();
        for (int l = LC - 1; l >= 0; l--) begin
            for (int s = 0; s < SPL; s++) begin
                sb.push_back({1'b1, (s == 0), 32'(l), 32'(s)});
            end
        end
        held = '0;
        if (stall_k > 0) held = {2'b00, sb[stall_k-1][63:0]};

        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        seen_done = 1'b0;
        while (!seen_done && n < 80) begin
            if (n == 0) check("busy_in_cost", CW'(busy), CW'(1));
            if (n == 1) check("diff_after_cost", CW'(diff_cost), CW'(ed));
            if (stall_len > 0 && n >= stall_k + 2 && n <= stall_k + 1 + stall_len)
                check("stall_hold", backprop_controll, held);
            if (backprop_controll[CW-1]) begin
                if (sb.size() == 0) begin
                    check("extra_word", backprop_controll, '0);
                end else begin
                    exp_w = sb.pop_front();
                    check("ctrl_word", backprop_controll, exp_w);
                end
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_latency", CW'(n), CW'(14 + stall_len));
                check("busy_at_done", CW'(busy), CW'(0));
            end
            stall = (stall_len > 0 && n >= stall_k + 1 && n < stall_k + 1 + stall_len);
            start = poke && (n == 5 || done);
            if (!seen_done) begin
                @(negedge clk);
                n++;
            end
        end
        if (!seen_done) check("done_timeout", CW'(0), CW'(1));
        check("word_count_left", CW'(sb.size()), CW'(0));
        @(negedge clk);
        start = 1'b0;
        stall = 1'b0;
        check("done_width", CW'(done), CW'(0));
        check("no_restart_busy", CW'(busy), CW'(0));
        repeat (2) @(negedge clk);
        check("idle_ctrl", backprop_controll, '0);
        check("no_restart_busy2", CW'(busy), CW'(0));
        check("diff_held", CW'(diff_cost), CW'(ed));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{p: 48'h0180_FE00_0040, t: 48'h0080_0100_0040,
                    d_wrap: 48'h0100_FD00_0000, d_sat: 48'h0100_FD00_0000};
        vecs[1] = '{p: 48'h7F00_8000_1234, t: 48'h8100_0001_1234,
                    d_wrap: 48'hFE00_7FFF_0000, d_sat: 48'h7FFF_8000_0000};
        vecs[2] = '{p: 48'h0000_7FFF_FFFF, t: 48'h0001_FFFF_7FFF,
                    d_wrap: 48'hFFFF_8000_8000, d_sat: 48'hFFFF_7FFF_8000};

        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        predict_value = '0;
        target = '0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", backprop_controll, '0);
        check("rst_diff", CW'(diff_cost), '0);
        check("rst_busy", CW'(busy), '0);
        check("rst_done", CW'(done), '0);
        reset = 1'b0;
        @(negedge clk);

        // Cost vectors, each driving a full unstalled pass.
        for (int i = 0; i < 3; i++) begin
            run_pass(vecs[i], 0, 0, 1'b0);
        end

        // Stall 3 cycles in front of (2,1).
        run_pass(vecs[0], 4, 3, 1'b0);

        // Start pulses mid-run and on the done cycle.
        run_pass(vecs[2], 0, 0, 1'b1);

        // Reset held 2 cycles mid-RUN.
        predict_value = vecs[0].p;
        target        = vecs[0].t;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_busy", CW'(busy), CW'(1));
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("midrun_rst_ctrl", backprop_controll, '0);
        check("midrun_rst_diff", CW'(diff_cost), '0);
        check("midrun_rst_busy", CW'(busy), '0);
        check("midrun_rst_done", CW'(done), '0);
        repeat (3) @(negedge clk);
        check("post_rst_idle_ctrl", backprop_controll, '0);
        check("post_rst_idle_busy", CW'(busy), '0);

        // Recovery pass after reset.
        run_pass(vecs[1], 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
